// File: rtl/priority_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the priority arbiter
// and its lowest-set-bit encoder tree.
package priority_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of radix-split levels needed to cover width leaves.
    function automatic int tree_levels(input int width, input int split);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < width) begin
            span = span * split;
            lvl  = lvl + 1;
        end
        return (lvl < 1) ? 1 : lvl;
    endfunction

    // Base index of a level inside the flattened node vector (level 1 first).
    function automatic int node_offset(input int padw, input int split, input int level);
        int off;
        int cnt;
        off = 0;
        cnt = padw;
        for (int l = 1; l < level; l++) begin
            cnt = cnt / split;
            off = off + cnt;
        end
        return off;
    endfunction

endpackage

// File: rtl/priority_arbiter_rr_tree.sv
// Lowest-set-bit to one-hot encoder. IMPLEMENTATION 0 builds a radix-SPLIT
// tree over req zero-extended to a power of SPLIT; any other value uses x & -x.
module priority_to_onehot_tree
    import priority_arbiter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot
);

    localparam int S = (SPLIT < 2) ? 2 : SPLIT;

    if (IMPLEMENTATION == 0) begin : g_tree
        localparam int LEVELS = tree_levels(WIDTH, S);
        localparam int PADW   = S ** LEVELS;
        localparam int NODES  = node_offset(PADW, S, LEVELS + 1);

        logic [PADW-1:0]  leaf_s;
        logic [NODES-1:0] any_s;
        logic [NODES-1:0] sel_s;

        function automatic logic [S-1:0] low_mask(input int pos);
            logic [S-1:0] m;
            for (int k = 0; k < S; k++) begin
                m[k] = (k < pos);
            end
            return m;
        endfunction

        assign leaf_s = PADW'(req);

        // Group-occupancy bottom-up, then winning-branch select top-down.
        always_comb begin
            any_s = '0;
            sel_s = '0;
            for (int n = 0; n < PADW / S; n++) begin
                any_s[n] = |leaf_s[n*S +: S];
            end
            for (int l = 2; l <= LEVELS; l++) begin
                for (int n = 0; n < PADW / (S ** l); n++) begin
                    any_s[node_offset(PADW, S, l) + n] =
                        |any_s[node_offset(PADW, S, l - 1) + n*S +: S];
                end
            end
            sel_s[NODES-1] = any_s[NODES-1];
            for (int l = LEVELS - 1; l >= 1; l--) begin
                for (int n = 0; n < PADW / (S ** l); n++) begin
                    sel_s[node_offset(PADW, S, l) + n] =
                        sel_s[node_offset(PADW, S, l + 1) + n / S]
                        & any_s[node_offset(PADW, S, l) + n]
                        & ~|(any_s[node_offset(PADW, S, l) + (n / S) * S +: S]
                             & low_mask(n % S));
                end
            end
        end

        // A leaf wins when its group is selected and no lower sibling requests.
        always_comb begin
            onehot = '0;
            for (int i = 0; i < WIDTH; i++) begin
                onehot[i] = sel_s[i / S] & leaf_s[i]
                            & ~|(leaf_s[(i / S) * S +: S] & low_mask(i % S));
            end
        end
    end else begin : g_flat
        assign onehot = req & (~req + WIDTH'(1));
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered fixed-priority / round-robin arbiter with valid/ready grant.
// Define PRIORITY_ARBITER_RR_LOCK_EN to hold a pending grant until transfer.
module priority_arbiter_rr
    import priority_arbiter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int MODE           = 1,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            req,
    output logic [WIDTH-1:0]            gnt,
    output logic [idx_width(WIDTH)-1:0] gnt_idx,
    output logic                        gnt_vld,
    input  logic                        gnt_rdy
);

    localparam int WIDTH_LOG = idx_width(WIDTH);

    if ((SPLIT < 2) || ((SPLIT & (SPLIT - 1)) != 0)) begin : g_bad_split
        $error("priority_arbiter_rr: SPLIT must be a power of 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("priority_arbiter_rr: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0]     gnt_q, gnt_d;
    logic [WIDTH_LOG-1:0] gnt_idx_q, gnt_idx_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;

    logic [WIDTH-1:0] above_s;
    logic [WIDTH-1:0] masked_s;
    logic [WIDTH-1:0] first_req_s;
    logic [WIDTH-1:0] first_mask_s;
    logic [WIDTH-1:0] pick_s;
    logic             xfer_s;
    logic             drop_s;
    logic             load_s;

    function automatic logic [WIDTH_LOG-1:0] onehot_to_idx(input logic [WIDTH-1:0] oh);
        logic [WIDTH_LOG-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | ({WIDTH_LOG{oh[i]}} & WIDTH_LOG'(i));
        end
        return idx;
    endfunction

    assign xfer_s = gnt_vld_q & gnt_rdy;

`ifdef PRIORITY_ARBITER_RR_LOCK_EN
    assign drop_s = 1'b0;
`else
    assign drop_s = gnt_vld_q & ~|(gnt_q & req);
`endif

    assign load_s = ~gnt_vld_q | xfer_s | drop_s;

    // Pointer follows the grant actually taken; a withdrawn grant leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
            ptr_d = gnt_idx_q;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Mask is built from ptr_d so a back-to-back reload already skips the grant just taken.
    always_comb begin
        above_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            above_s[i] = (WIDTH_LOG'(i) > ptr_d);
        end
    end

    assign masked_s = req & above_s;

    priority_to_onehot_tree #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_enc_req (
        .req    (req),
        .onehot (first_req_s)
    );

    priority_to_onehot_tree #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_enc_mask (
        .req    (masked_s),
        .onehot (first_mask_s)
    );

    assign pick_s = ((MODE == int'(ARB_RR)) && (|masked_s)) ? first_mask_s : first_req_s;

    // Grant register next state: reload on idle, transfer or withdrawal, else hold.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        if (load_s) begin
            gnt_d     = pick_s;
            gnt_idx_d = onehot_to_idx(pick_s);
            gnt_vld_d = |req;
        end else begin
            gnt_d     = gnt_q;
            gnt_idx_d = gnt_idx_q;
            gnt_vld_d = gnt_vld_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= WIDTH_LOG'(WIDTH - 1);
        end else begin
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr: round-robin, fixed-priority and
// a padded WIDTH=5/SPLIT=4 instance sharing one clock and reset.
module tb_priority_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] rr_req, rr_gnt;
    logic [2:0] rr_idx;
    logic       rr_vld, rr_rdy;

    logic [7:0] fx_req, fx_gnt;
    logic [2:0] fx_idx;
    logic       fx_vld, fx_rdy;

    logic [4:0] w5_req, w5_gnt;
    logic [2:0] w5_idx;
    logic       w5_vld, w5_rdy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp8;
    logic [7:0] lock_exp;

    always #5 clk = ~clk;

    priority_arbiter_rr #(.WIDTH(8), .SPLIT(2), .MODE(1), .IMPLEMENTATION(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(rr_req), .gnt(rr_gnt),
        .gnt_idx(rr_idx), .gnt_vld(rr_vld), .gnt_rdy(rr_rdy)
    );

    priority_arbiter_rr #(.WIDTH(8), .SPLIT(2), .MODE(0), .IMPLEMENTATION(1)) dut_fx (
        .clk(clk), .rst_n(rst_n), .req(fx_req), .gnt(fx_gnt),
        .gnt_idx(fx_idx), .gnt_vld(fx_vld), .gnt_rdy(fx_rdy)
    );

    priority_arbiter_rr #(.WIDTH(5), .SPLIT(4), .MODE(1), .IMPLEMENTATION(0)) dut_w5 (
        .clk(clk), .rst_n(rst_n), .req(w5_req), .gnt(w5_gnt),
        .gnt_idx(w5_idx), .gnt_vld(w5_vld), .gnt_rdy(w5_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef PRIORITY_ARBITER_RR_LOCK_EN
        lock_exp = 8'h10;
`else
        lock_exp = 8'h00;
`endif
        rst_n  = 1'b0;
        rr_req = 8'h00; rr_rdy = 1'b0;
        fx_req = 8'h00; fx_rdy = 1'b0;
        w5_req = 5'h00; w5_rdy = 1'b0;
        tick();
        tick();
        check("rst_rr_gnt", 32'(rr_gnt), 32'h0);
        check("rst_rr_vld", 32'(rr_vld), 32'h0);
        check("rst_rr_idx", 32'(rr_idx), 32'h0);
        check("rst_fx_vld", 32'(fx_vld), 32'h0);
        check("rst_w5_vld", 32'(w5_vld), 32'h0);

        // Continuous traffic on all three instances.
        rst_n  = 1'b1;
        rr_req = 8'hFF;       rr_rdy = 1'b1;
        fx_req = 8'b1010_0100; fx_rdy = 1'b1;
        w5_req = 5'b10001;    w5_rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp8 = 8'h01 << (k % 8);
            check("rr_seq_idx", 32'(rr_idx), 32'(k % 8));
            check("rr_seq_gnt", 32'(rr_gnt), 32'(exp8));
            check("rr_seq_vld", 32'(rr_vld), 32'h1);
            check("fx_gnt", 32'(fx_gnt), 32'h04);
            check("fx_idx", 32'(fx_idx), 32'h2);
            check("w5_gnt", 32'(w5_gnt), (k % 2 == 0) ? 32'h01 : 32'h10);
            check("w5_idx", 32'(w5_idx), (k % 2 == 0) ? 32'h0 : 32'h4);
        end

        // Reset while a grant is pending drops it; first grant after is lowest req.
        rst_n = 1'b0;
        tick();
        check("rstpend_gnt", 32'(rr_gnt), 32'h0);
        check("rstpend_vld", 32'(rr_vld), 32'h0);
        rst_n  = 1'b1;
        rr_req = 8'h88;
        rr_rdy = 1'b0;
        tick();
        check("after_rst_gnt", 32'(rr_gnt), 32'h08);
        check("after_rst_idx", 32'(rr_idx), 32'h3);

        // Back-pressure holds the grant, then the pointer moves past it.
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        rr_req = 8'h81;
        rr_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_gnt", 32'(rr_gnt), 32'h01);
        end
        rr_rdy = 1'b1;
        tick();
        check("hold_next_gnt", 32'(rr_gnt), 32'h80);
        tick();
        check("hold_wrap_gnt", 32'(rr_gnt), 32'h01);

        // Request drop on a pending grant: withdraw (no lock) or hold (lock).
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        rr_req = 8'h10;
        rr_rdy = 1'b0;
        tick();
        check("drop_first_gnt", 32'(rr_gnt), 32'h10);
        rr_req = 8'h02;
        tick();
        check("drop_gnt", 32'(rr_gnt), (lock_exp != 8'h00) ? 32'(lock_exp) : 32'h02);
        rr_req = 8'h21;
        tick();
        check("drop_ptr_kept", 32'(rr_gnt), (lock_exp != 8'h00) ? 32'(lock_exp) : 32'h01);
        rr_rdy = 1'b1;
        tick();
        check("drop_release", 32'(rr_gnt), 32'h20);
        check("drop_release_idx", 32'(rr_idx), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_rr.md
PRIORITY_ARBITER_RR -- requirements
Module: priority_arbiter_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of requesters, any value >= 2.
REQ-002 SHALL have parameter SPLIT, default 2: encoder tree radix, a power of 2; any other value SHALL raise an elaboration $error.
REQ-003 SHALL have parameter MODE, default 1: 0 = fixed priority, 1 = round-robin.
REQ-004 SHALL have parameter IMPLEMENTATION, default 0: forwarded unchanged to the encoder sub-module.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port req, input, WIDTH: request vector, bit i = requester i.
REQ-008 SHALL have port gnt, output, WIDTH: registered one-hot grant, all-zero when gnt_vld=0.
REQ-009 SHALL have port gnt_idx, output, $clog2(WIDTH): binary index of the set gnt bit, 0 when gnt_vld=0.
REQ-010 SHALL have port gnt_vld, output, 1: grant valid.
REQ-011 SHALL have port gnt_rdy, input, 1: grant accepted by consumer.

Function
REQ-012 SHALL complete a transfer on any rising edge where gnt_vld=1 and gnt_rdy=1.
REQ-013 SHALL load a new grant when gnt_vld=0 or a transfer completes; otherwise gnt, gnt_idx and gnt_vld SHALL hold.
REQ-014 SHALL make a load with req=0 give gnt_vld=0, gnt=0 and gnt_idx=0 on the next cycle.
REQ-015 SHALL make a load with req!=0 give gnt_vld=1 next cycle, so latency from req to grant is exactly 1 cycle.
REQ-016 SHALL sustain back-to-back transfers: a transfer and a new load in the same edge, throughput 1 grant/cycle.
REQ-017 SHALL, for MODE=0, grant the lowest set index of req.
REQ-018 SHALL, for MODE=1, keep pointer ptr (WIDTH_LOG bits) = index of the last transferred grant.
REQ-019 SHALL, for MODE=1, form masked = req AND bits strictly above ptr; grant lowest set bit of masked if nonzero, else lowest set bit of req.
REQ-020 SHALL update ptr only on a completed transfer, to gnt_idx; ptr=WIDTH-1 SHALL give an empty mask, i.e. wrap to bit 0.
REQ-021 SHALL ignore req bits above WIDTH-1 internally, with non-power-of-SPLIT WIDTH zero-extended.
REQ-022 SHALL keep gnt always one-hot or zero, and gnt_idx always consistent with gnt.

Reset
REQ-023 SHALL, on rst_n=0 at a rising edge, set gnt=0, gnt_idx=0, gnt_vld=0 and ptr=WIDTH-1, regardless of gnt_rdy or req.
REQ-024 SHALL, when reset is asserted while a grant is pending, drop it without a transfer; the first grant after release is lowest set req.

Configuration
REQ-025 SHALL use macro PRIORITY_ARBITER_RR_LOCK_EN; when defined, a pending grant SHALL hold until transfer even if its req bit deasserts.
REQ-026 SHALL, when PRIORITY_ARBITER_RR_LOCK_EN is undefined, withdraw a pending grant whose req bit is 0 and reload from current req the same edge, leaving ptr unchanged.

Structure
REQ-027 SHALL place the MODE enum (ARB_FIXED=0, ARB_RR=1) and an index-width helper function in package priority_arbiter_pkg.
REQ-028 SHALL implement both lowest-set-bit searches with two instances of sub-module priority_to_onehot_tree (WIDTH, SPLIT, IMPLEMENTATION).
REQ-029 SHALL use a one-hot-to-binary OR-reduction for gnt_idx and SHALL NOT use a second encoder.

Verification (WIDTH=8, SPLIT=2 unless stated)
REQ-030 SHALL cover: MODE=1, req=8'hFF, gnt_rdy=1 constant after reset -> gnt_idx sequence 0,1,...,7,0 on consecutive cycles.
REQ-031 SHALL cover: MODE=0, req=8'b1010_0100, gnt_rdy=1 -> gnt=8'h04 every cycle.
REQ-032 SHALL cover: MODE=1, req=8'h81, gnt_rdy=0 for 3 cycles then 1 -> gnt=8'h01 held 4 cycles, then 8'h80.
REQ-033 SHALL cover: LOCK_EN undefined, grant 8'h10 pending, req drops to 8'h02 -> next cycle gnt=8'h02, ptr unchanged; LOCK_EN defined -> gnt stays 8'h10.
REQ-034 SHALL cover: rst_n=0 one cycle while gnt_vld=1 -> next cycle gnt=0, gnt_vld=0; then req=8'h88 -> gnt=8'h08.
REQ-035 SHALL cover: WIDTH=5, SPLIT=4, MODE=1, req=5'b10001 -> grants alternate 5'b00001, 5'b10000 with zero upper padding effects.
